// File: rtl/aq_hpcp_cnt_bank.sv
// ---------------------------------------------------------------------------
// aq_hpcp_cnt_bank
//
// Bank of NUM_CNT hardware performance counters for the PMU. Each channel
// counts an already-selected single-bit event through one registered event
// stage. Counters share one CSR write port, and each channel has an inhibit
// and a sticky overflow flag. An optional level-type overflow interrupt can
// be built in.
//
// Optional feature macro: AQ_HPCP_OF_IRQ_EN
//   defined   : cnt_of_irq is registered as |(cnt_of & of_irq_en)
//   undefined : no interrupt register; cnt_of_irq is tied to 0 and
//               of_irq_en is ignored
//
// Parameters
//   NUM_CNT    number of counter channels (1..32)
//   CNT_WIDTH  width of each counter (8..64)
//   IDX_WIDTH  write-index width, max(1, ceil(log2(NUM_CNT)))
//
// Ports
//   forever_cpuclk  free-running core clock, all state on its rising edge
//   cpurst          asynchronous active-high reset
//   hpcp_cnt_en     global count enable, sampled in the increment cycle
//   cnt_inhibit     per-channel inhibit, sampled in the event cycle
//   cnt_event       per-channel event pulse, +1 per cycle high
//   cnt_wen         CSR write strobe
//   cnt_widx        channel written (out-of-range index writes nothing)
//   hpcp_wdata      CSR write data
//   of_clr          write-1-to-clear for the sticky overflow flags
//   of_irq_en       per-channel overflow interrupt enable
//   cnt_value       packed counters, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   cnt_of          sticky overflow flags
//   cnt_of_irq      registered overflow interrupt request
// ---------------------------------------------------------------------------
module aq_hpcp_cnt_bank #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 64,
  parameter int IDX_WIDTH = 2
) (
  input  logic                           forever_cpuclk,
  input  logic                           cpurst,
  input  logic                           hpcp_cnt_en,
  input  logic [NUM_CNT-1:0]             cnt_inhibit,
  input  logic [NUM_CNT-1:0]             cnt_event,
  input  logic                           cnt_wen,
  input  logic [IDX_WIDTH-1:0]           cnt_widx,
  input  logic [CNT_WIDTH-1:0]           hpcp_wdata,
  input  logic [NUM_CNT-1:0]             of_clr,
  input  logic [NUM_CNT-1:0]             of_irq_en,
  output logic [NUM_CNT*CNT_WIDTH-1:0]   cnt_value,
  output logic [NUM_CNT-1:0]             cnt_of,
  output logic                           cnt_of_irq
);

  logic [NUM_CNT-1:0]                evt_d, evt_q;
  logic [NUM_CNT-1:0]                inc;
  logic [NUM_CNT-1:0]                of_set;
  logic [NUM_CNT-1:0]                of_d, of_q;
  // Packed 2-D so the flat output is a straight assignment with channel i
  // landing at [i*CNT_WIDTH +: CNT_WIDTH].
  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_d, cnt_q;

  // Next-state logic for the event stage, counters and overflow flags.
  always_comb begin
    // NOTE: every variable written here gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch; blocking
    // assignments are correct in combinational logic.
    evt_d  = cnt_event & ~cnt_inhibit;
    inc    = evt_q & {NUM_CNT{hpcp_cnt_en}};
    cnt_d  = cnt_q;
    of_set = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      // Indices >= NUM_CNT never match any channel, so such writes are no-ops.
      // A write beats a same-cycle increment, and that increment is lost.
      if (cnt_wen && (32'(cnt_widx) == i)) begin
        cnt_d[i] = hpcp_wdata;
      end else if (inc[i]) begin
        cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(1);
        of_set[i] = &cnt_q[i];
      end
    end
    // Set has priority over a same-cycle clear.
    of_d = (of_q & ~of_clr) | of_set;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the counters are individual flops, so all are reset.
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      evt_q <= '0;
      cnt_q <= '0;
      of_q  <= '0;
    end else begin
      evt_q <= evt_d;
      cnt_q <= cnt_d;
      of_q  <= of_d;
    end
  end

  assign cnt_value = cnt_q;
  assign cnt_of    = of_q;

`ifdef AQ_HPCP_OF_IRQ_EN
  logic irq_d, irq_q;

  // Level interrupt, one cycle behind the flags it summarises.
  always_comb begin
    irq_d = |(of_q & of_irq_en);
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign cnt_of_irq = irq_q;
`else
  // Interrupt not built; the enable input is kept only for port compatibility.
  logic unused_of_irq_en;
  assign unused_of_irq_en = ^of_irq_en;
  assign cnt_of_irq       = 1'b0;
`endif

endmodule

// File: tb/tb_aq_hpcp_cnt_bank.sv
// ---------------------------------------------------------------------------
// tb_aq_hpcp_cnt_bank
//
// Self-checking bench for aq_hpcp_cnt_bank. Main instance: NUM_CNT=4,
// CNT_WIDTH=8 so wraps are cheap to reach. A second instance with NUM_CNT=3
// exercises a write index that is representable but out of range.
// A behavioural model produces an expected snapshot at every clock edge; the
// snapshot is queued and compared against the DUT one step after the edge.
// ---------------------------------------------------------------------------
module tb_aq_hpcp_cnt_bank;

`ifdef AQ_HPCP_OF_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic [N-1:0]     inhibit = '0;
  logic [N-1:0]     event_i = '0;
  logic             wen = 1'b0;
  logic [1:0]       widx = '0;
  logic [W-1:0]     wdata = '0;
  logic [N-1:0]     of_clr = '0;
  logic [N-1:0]     irq_en = '0;
  logic [N*W-1:0]   value;
  logic [N-1:0]     of_o;
  logic             irq;

  logic             wen3 = 1'b0;
  logic [1:0]       widx3 = '0;
  logic [3*W-1:0]   value3;
  logic [2:0]       of3;
  logic             irq3;

  always #5 clk = ~clk;

  aq_hpcp_cnt_bank #(.NUM_CNT(N), .CNT_WIDTH(W), .IDX_WIDTH(2)) u_dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .hpcp_cnt_en    (en),
    .cnt_inhibit    (inhibit),
    .cnt_event      (event_i),
    .cnt_wen        (wen),
    .cnt_widx       (widx),
    .hpcp_wdata     (wdata),
    .of_clr         (of_clr),
    .of_irq_en      (irq_en),
    .cnt_value      (value),
    .cnt_of         (of_o),
    .cnt_of_irq     (irq)
  );

  aq_hpcp_cnt_bank #(.NUM_CNT(3), .CNT_WIDTH(W), .IDX_WIDTH(2)) u_dut3 (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .hpcp_cnt_en    (1'b1),
    .cnt_inhibit    (3'b000),
    .cnt_event      (3'b000),
    .cnt_wen        (wen3),
    .cnt_widx       (widx3),
    .hpcp_wdata     (wdata),
    .of_clr         (3'b000),
    .of_irq_en      (3'b000),
    .cnt_value      (value3),
    .cnt_of         (of3),
    .cnt_of_irq     (irq3)
  );

  typedef struct {
    logic [N-1:0][W-1:0] cnt;
    logic [N-1:0]        of;
    logic                irq;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [N-1:0]        m_evt;
  logic [N-1:0][W-1:0] m_cnt;
  logic [N-1:0]        m_of;
  logic                m_irq;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan(input int ch);
    return value[ch*W +: W];
  endfunction

  task automatic model_reset();
    m_evt = '0;
    m_cnt = '0;
    m_of  = '0;
    m_irq = 1'b0;
  endtask

  // One rising edge of the model, using the inputs the DUT sampled.
  task automatic model_step();
    logic [N-1:0][W-1:0] n_cnt;
    logic [N-1:0]        set;
    n_cnt = m_cnt;
    set   = '0;
    for (int i = 0; i < N; i++) begin
      if (wen && int'(widx) == i) begin
        n_cnt[i] = wdata;
      end else if (m_evt[i] && en) begin
        if (m_cnt[i] == 8'hFF) begin
          n_cnt[i] = 8'h00;
          set[i]   = 1'b1;
        end else begin
          n_cnt[i] = m_cnt[i] + 8'd1;
        end
      end
    end
    m_irq = IRQ_ON ? |(m_of & irq_en) : 1'b0;
    m_of  = (m_of & ~of_clr) | set;
    m_cnt = n_cnt;
    m_evt = event_i & ~inhibit;
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.cnt = m_cnt;
    e.of  = m_of;
    e.irq = m_irq;
    return e;
  endfunction

  task automatic compare_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < N; i++)
      check($sformatf("cnt%0d", i), 64'(chan(i)), 64'(e.cnt[i]));
    check("cnt_of", 64'(of_o), 64'(e.of));
    check("cnt_of_irq", 64'(irq), 64'(e.irq));
  endtask

  // Advance one clock: model the edge, queue expectation, compare after it.
  task automatic cyc();
    @(posedge clk);
    model_step();
    sb_q.push_back(snap());
    #1;
    compare_sb();
  endtask

  task automatic idle_inputs();
    event_i = '0;
    inhibit = '0;
    en      = 1'b1;
    wen     = 1'b0;
    of_clr  = '0;
  endtask

  task automatic write(input int ch, input logic [W-1:0] d);
    wen   = 1'b1;
    widx  = 2'(ch);
    wdata = d;
    cyc();
    wen   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("rst_value", 64'(value), 64'd0);
    check("rst_of", 64'(of_o), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset and count: 5 events on channel 2.
    for (int k = 1; k <= 7; k++) begin
      event_i = (k <= 5) ? 4'b0100 : 4'b0000;
      cyc();
      check("count_ch2", 64'(chan(2)), 64'((k - 1) > 5 ? 5 : (k - 1)));
    end
    idle_inputs();
    check("count_ch0", 64'(chan(0)), 64'd0);

    // Inhibit blocks the event cycle.
    event_i = 4'b0001; inhibit = 4'b0001; cyc();
    idle_inputs(); cyc(); cyc();
    // Enable low in the increment cycle blocks.
    event_i = 4'b0001; cyc();
    idle_inputs(); en = 1'b0; cyc();
    en = 1'b1; cyc();
    check("blocked_ch0", 64'(chan(0)), 64'd0);
    // Neither control active: counts.
    event_i = 4'b0001; cyc();
    idle_inputs(); cyc();
    check("unblocked_ch0", 64'(chan(0)), 64'd1);

    // Write priority: event in t-1, write in t -> write value, no +1.
    write(1, 8'd10);
    check("wr_ch1", 64'(chan(1)), 64'd10);
    event_i = 4'b0010; cyc();
    event_i = 4'b0000; write(1, 8'h5A);
    check("wr_drop_inc", 64'(chan(1)), 64'h5A);
    cyc();
    check("wr_drop_hold", 64'(chan(1)), 64'h5A);
    // Event in t together with write in t -> write, then +1.
    event_i = 4'b0010; write(1, 8'h20);
    event_i = 4'b0000;
    check("wr_evt_same", 64'(chan(1)), 64'h20);
    cyc();
    check("wr_evt_next", 64'(chan(1)), 64'h21);

    // Out-of-range write on the 3-channel instance changes nothing.
    @(negedge clk);
    wen3 = 1'b1; widx3 = 2'd3; wdata = 8'h77;
    @(negedge clk);
    wen3 = 1'b0;
    check("oor_write", 64'(value3), 64'd0);
    wen3 = 1'b1; widx3 = 2'd2;
    @(negedge clk);
    wen3 = 1'b0;
    check("inrange_write", 64'(value3), 64'h77_0000);
    // Main DUT saw no writes during that detour; resync the model by edges.
    sb_q.delete();
    cyc();

    // Wrap and sticky flag on channel 3.
    irq_en = 4'b0100;
    write(3, 8'hFF);
    check("wr_ff_no_of", 64'(of_o[3]), 64'd0);
    event_i = 4'b1000; cyc();
    idle_inputs(); cyc();
    check("wrap_cnt3", 64'(chan(3)), 64'd0);
    check("wrap_of3", 64'(of_o[3]), 64'd1);
    write(3, 8'hFF);
    event_i = 4'b1000; cyc();
    idle_inputs(); of_clr = 4'b1000; cyc();
    check("set_beats_clr", 64'(of_o[3]), 64'd1);
    cyc();
    check("lone_clr", 64'(of_o[3]), 64'd0);
    of_clr = '0;
    cyc(); cyc();
    check("irq_ch3_masked", 64'(irq), 64'd0);

    // Overflow on channel 0 only: not enabled for interrupt.
    write(0, 8'hFF);
    event_i = 4'b0001; cyc();
    idle_inputs(); cyc();
    check("of0", 64'(of_o[0]), 64'd1);
    cyc(); cyc();
    check("irq_ch0_masked", 64'(irq), 64'd0);

    // Overflow on channel 2: interrupt one cycle after the flag.
    write(2, 8'hFF);
    event_i = 4'b0100; cyc();
    idle_inputs(); cyc();
    check("of2", 64'(of_o[2]), 64'd1);
    check("irq_lag", 64'(irq), 64'd0);
    cyc();
    check("irq_on", 64'(irq), 64'(IRQ_ON));
    of_clr = 4'b0100; cyc();
    of_clr = '0;
    check("of2_clr", 64'(of_o[2]), 64'd0);
    check("irq_hold", 64'(irq), 64'(IRQ_ON));
    cyc();
    check("irq_off", 64'(irq), 64'd0);

    // Random traffic across all channels, wraps forced via near-max writes.
    for (int k = 0; k < 300; k++) begin
      event_i = 4'($urandom);
      inhibit = 4'($urandom) & 4'($urandom);
      en      = ($urandom_range(0, 7) != 0);
      wen     = ($urandom_range(0, 5) == 0);
      widx    = 2'($urandom);
      wdata   = ($urandom_range(0, 1) != 0) ? 8'hFE : 8'($urandom);
      of_clr  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      irq_en  = 4'($urandom);
      cyc();
    end
    idle_inputs();

    // Reset mid-operation discards pending events, no clock needed.
    event_i = 4'b1111; cyc();
    idle_inputs();
    #1 rst = 1'b1;
    model_reset();
    #1;
    sb_q.push_back(snap());
    compare_sb();
    rst = 1'b0;
    cyc(); cyc();
    check("rst_discard", 64'(value), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
